psm_ramp_sequencer: RTL and testbench
=====================================

Name: psm_ramp_sequencer

Overview:
- Sequences the phase-shift modulator: start-up, soft ramp of SPS/DPS commands, tracking, controlled shutdown and fault trip.
- Sits between the control/register layer and the PSM controller.
- Drives the modulator reset plus the SPS/DPS value and sign inputs.
- All command changes are applied only on carrier-period ticks, so the modulator never sees a mid-period jump larger than one step.

Parameters:
- BITS_DATA, 16, width of phase/frequency words
- ARM_PERIODS, 4, carrier periods spent at zero phase before ramping starts (1..255)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- iENABLE  in  1  level; 1 = run converter, 0 = controlled shutdown
- iCLEAR  in  1  pulse; clears a latched fault
- iFAULT  in  1  level; hardware/protection fault
- iPERIOD_TICK  in  1  one-cycle pulse per carrier period, from the modulator counter wrap
- iFREQUENCY  in  BITS_DATA  carrier period in clocks; magnitude limit LIM = iFREQUENCY-2
- iSTEP  in  BITS_DATA  max magnitude change per tick; 0 = jump straight to target
- iSPS_target, iDPS_target  in  BITS_DATA  target magnitudes
- iSPS_target_sign, iDPS_target_sign  in  1  target signs (1 = negative)
- oPSM_RST  out  1  modulator reset
- oSPS_value, oDPS_value  out  BITS_DATA  current command magnitudes
- oSPS_sign, oDPS_sign  out  1  current command signs
- oSTATE  out  3  0 IDLE, 1 ARM, 2 RAMP, 3 RUN, 4 RAMPDOWN, 5 FAULT
- oDONE  out  1  1 while in RUN

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; oPSM_RST=1; values 0; signs 0; oDONE=0; arm counter 0.
- Internal commands are held as signed BITS_DATA+1 values, cur_s and cur_d.
- Target conversion: clamp magnitude to LIM (mag>LIM gives LIM), then negate if the sign bit is set.
- Outputs are derived from cur: value = |cur|, sign = (cur<0). Zero always has sign 0.
- Ramp rule, applied on a tick, per channel: diff = tgt-cur.
  - If |diff| <= iSTEP, or iSTEP==0: cur = tgt.
  - Otherwise cur moves iSTEP toward tgt.
  - A sign reversal therefore passes linearly through zero. Each channel's arithmetic must be at least 1 bit wider than BITS_DATA so it cannot overflow.
- Targets are sampled continuously; only ticks move cur.
- Outputs change on the cycle after the tick is sampled.
- IDLE: oPSM_RST=1, cur=0. Go to ARM when iENABLE=1 and iFAULT=0.
- ARM:
  - On entry, oPSM_RST drops to 0 and the counter clears.
  - Each tick increments the counter; at ARM_PERIODS ticks, go to RAMP.
  - iENABLE=0 in ARM: go to IDLE.
- RAMP:
  - Ramp both channels each tick.
  - When both cur equal their targets after an update, go to RUN.
  - iENABLE=0: go to RAMPDOWN.
- RUN:
  - oDONE=1.
  - A target change (cur != converted target) on any cycle returns to RAMP; the first movement happens on the next tick.
  - iENABLE=0: go to RAMPDOWN.
- RAMPDOWN:
  - Ramp both channels toward 0 using the same rule.
  - When both reach 0, go to IDLE; oPSM_RST reasserts the cycle after.
  - iENABLE=1 again: go back to RAMP from the current cur, with no reset pulse.
- FAULT:
  - iFAULT=1 in any non-IDLE state enters FAULT on the next edge: oPSM_RST=1 and cur=0 immediately (no ramp). iFAULT in IDLE also enters FAULT.
  - Leave FAULT only on iCLEAR=1 with iFAULT=0, and always to IDLE; a restart needs iENABLE to be asserted afresh (its level is re-evaluated in IDLE).
- Priority per cycle: RST > iFAULT > iENABLE=0 > tick ramp > target-change detection.
- iFREQUENCY changes:
  - LIM is re-evaluated every cycle.
  - If cur exceeds the new LIM, the next tick ramps it down toward the new clamped target; no instantaneous clamp outside FAULT.
  - iFREQUENCY<2: LIM = 0.
- Reset mid-ramp: everything returns to reset values the cycle after RST is sampled.

Test Plan:
- Start-up: iFREQUENCY=2000, iSTEP=100, SPS target +450, DPS target 0, ARM_PERIODS=4, enable.
  - oPSM_RST falls 1 cycle after enable.
  - 4 ticks in ARM.
  - SPS then steps 100,200,300,400,450 on successive ticks.
  - RUN/oDONE=1 after the 5th ramp tick.
- Sign reversal: RUN at SPS +150, iSTEP=100, target changes to -150.
  - Outputs 50/+, 50/-, 150/- on three ticks.
  - Passing through 0 is not required at this step size; with iSTEP=75, oSPS_value=0, oSPS_sign=0 appears at one tick.
- Clamp: iSTEP=0, iFREQUENCY=1000, DPS target 5000 → oDPS_value=998 one cycle after the first RAMP tick.
- Shutdown: RUN at SPS 300/DPS 200, iSTEP=100, iENABLE low.
  - Values 200/100, 100/0, 0/0.
  - Then IDLE, and oPSM_RST=1 on the following cycle.
  - Re-enabling during RAMPDOWN resumes RAMP with no reset pulse.
- Fault: iFAULT pulse mid-RAMP.
  - Next cycle: oPSM_RST=1, values 0, oSTATE=5.
  - iCLEAR while iFAULT=1 is ignored.
  - iCLEAR after iFAULT=0 gives IDLE.
- Simultaneous events: tick coincides with iFAULT → FAULT wins, no ramp update. RST asserted mid-RUN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/psm_ramp_sequencer.sv
// Phase-shift modulator sequencer: arm, soft ramp, run tracking, ramp-down and fault trip.
// Command changes are applied only on carrier-period ticks, at most one step per tick.
module psm_ramp_sequencer #(
    parameter int unsigned BITS_DATA   = 16,
    parameter int unsigned ARM_PERIODS = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iENABLE,
    input  logic                 iCLEAR,
    input  logic                 iFAULT,
    input  logic                 iPERIOD_TICK,
    input  logic [BITS_DATA-1:0] iFREQUENCY,
    input  logic [BITS_DATA-1:0] iSTEP,
    input  logic [BITS_DATA-1:0] iSPS_target,
    input  logic [BITS_DATA-1:0] iDPS_target,
    input  logic                 iSPS_target_sign,
    input  logic                 iDPS_target_sign,
    output logic                 oPSM_RST,
    output logic [BITS_DATA-1:0] oSPS_value,
    output logic [BITS_DATA-1:0] oDPS_value,
    output logic                 oSPS_sign,
    output logic                 oDPS_sign,
    output logic [2:0]           oSTATE,
    output logic                 oDONE
);

    localparam int unsigned CW = BITS_DATA + 1;
    localparam int unsigned AW = BITS_DATA + 2;
    localparam int unsigned NW = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_RAMP     = 3'd2,
        ST_RUN      = 3'd3,
        ST_RAMPDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic signed [CW-1:0]   cur_s_q, cur_s_d;
    logic signed [CW-1:0]   cur_d_q, cur_d_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic                   psm_rst_q, psm_rst_d;
    logic [BITS_DATA-1:0]   sps_val_q, dps_val_q;
    logic                   sps_sign_q, dps_sign_q;
    logic                   done_q;

    logic [BITS_DATA-1:0]   lim_c;
    logic signed [CW-1:0]   tgt_s_c, tgt_d_c;
    logic signed [CW-1:0]   up_s_c, up_d_c, dn_s_c, dn_d_c;

    // Clamp a target magnitude to the limit, then apply its sign.
    function automatic logic signed [CW-1:0] conv(input logic [BITS_DATA-1:0] mag,
                                                  input logic                 neg,
                                                  input logic [BITS_DATA-1:0] lim);
        logic [BITS_DATA-1:0] m;
        m = (mag > lim) ? lim : mag;
        return neg ? -$signed({1'b0, m}) : $signed({1'b0, m});
    endfunction

    // One ramp step toward tgt; difference carried in AW bits so it cannot overflow.
    function automatic logic signed [CW-1:0] ramp(input logic signed [CW-1:0] cur,
                                                  input logic signed [CW-1:0] tgt,
                                                  input logic [BITS_DATA-1:0] step);
        logic signed [AW-1:0] diff;
        logic signed [AW-1:0] stp;
        logic signed [AW-1:0] dmag;
        diff = AW'(tgt) - AW'(cur);
        stp  = $signed({2'b00, step});
        dmag = diff[AW-1] ? -diff : diff;
        if (step == '0 || dmag <= stp) begin
            return tgt;
        end
        if (diff[AW-1]) begin
            return CW'(AW'(cur) - stp);
        end
        return CW'(AW'(cur) + stp);
    endfunction

    function automatic logic [BITS_DATA-1:0] mag_of(input logic signed [CW-1:0] v);
        logic signed [CW-1:0] a;
        a = v[CW-1] ? -v : v;
        return BITS_DATA'(a);
    endfunction

    always_comb begin
        lim_c   = (iFREQUENCY < BITS_DATA'(2)) ? '0 : iFREQUENCY - BITS_DATA'(2);
        tgt_s_c = conv(iSPS_target, iSPS_target_sign, lim_c);
        tgt_d_c = conv(iDPS_target, iDPS_target_sign, lim_c);
        up_s_c  = ramp(cur_s_q, tgt_s_c, iSTEP);
        up_d_c  = ramp(cur_d_q, tgt_d_c, iSTEP);
        dn_s_c  = ramp(cur_s_q, '0, iSTEP);
        dn_d_c  = ramp(cur_d_q, '0, iSTEP);
    end

    // Next-state and command update; fault outranks everything but reset.
    always_comb begin
        state_d   = state_q;
        cur_s_d   = cur_s_q;
        cur_d_d   = cur_d_q;
        cnt_d     = cnt_q;
        psm_rst_d = psm_rst_q;

        if (iFAULT) begin
            state_d = ST_FAULT;
            cur_s_d = '0;
            cur_d_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cur_s_d = '0;
                    cur_d_d = '0;
                    if (iENABLE) begin
                        state_d = ST_ARM;
                        cnt_d   = '0;
                    end
                end
                ST_ARM: begin
                    if (!iENABLE) begin
                        state_d = ST_IDLE;
                    end else if (iPERIOD_TICK) begin
                        cnt_d = cnt_q + NW'(1);
                        if (({1'b0, cnt_q} + 9'd1) == 9'(ARM_PERIODS)) begin
                            state_d = ST_RAMP;
                        end
                    end
                end
                ST_RAMP: begin
                    if (!iENABLE) begin
                        state_d = ST_RAMPDOWN;
                    end else if (iPERIOD_TICK) begin
                        cur_s_d = up_s_c;
                        cur_d_d = up_d_c;
                        if (up_s_c == tgt_s_c && up_d_c == tgt_d_c) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!iENABLE) begin
                        state_d = ST_RAMPDOWN;
                    end else if (cur_s_q != tgt_s_c || cur_d_q != tgt_d_c) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMPDOWN: begin
                    if (iENABLE) begin
                        state_d = ST_RAMP;
                    end else if (iPERIOD_TICK) begin
                        cur_s_d = dn_s_c;
                        cur_d_d = dn_d_c;
                        if (dn_s_c == '0 && dn_d_c == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FAULT: begin
                    cur_s_d = '0;
                    cur_d_d = '0;
                    if (iCLEAR) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cur_s_d = '0;
                    cur_d_d = '0;
                end
            endcase
        end

        // Modulator reset: immediate in FAULT, one cycle late when IDLE is reached from a live state.
        psm_rst_d = (state_d == ST_FAULT)
                 || (((state_q == ST_IDLE) || (state_q == ST_FAULT)) && (state_d != ST_ARM));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cur_s_q    <= '0;
            cur_d_q    <= '0;
            cnt_q      <= '0;
            psm_rst_q  <= 1'b1;
            sps_val_q  <= '0;
            dps_val_q  <= '0;
            sps_sign_q <= 1'b0;
            dps_sign_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_s_q    <= cur_s_d;
            cur_d_q    <= cur_d_d;
            cnt_q      <= cnt_d;
            psm_rst_q  <= psm_rst_d;
            sps_val_q  <= mag_of(cur_s_d);
            dps_val_q  <= mag_of(cur_d_d);
            sps_sign_q <= cur_s_d[CW-1];
            dps_sign_q <= cur_d_d[CW-1];
            done_q     <= (state_d == ST_RUN);
        end
    end

    assign oPSM_RST   = psm_rst_q;
    assign oSPS_value = sps_val_q;
    assign oDPS_value = dps_val_q;
    assign oSPS_sign  = sps_sign_q;
    assign oDPS_sign  = dps_sign_q;
    assign oSTATE     = state_q;
    assign oDONE      = done_q;

endmodule

// File: tb/tb_psm_ramp_sequencer.sv
// Bench for psm_ramp_sequencer: integer reference model checked every cycle plus directed literal checks.
module tb_psm_ramp_sequencer;

    localparam int BD  = 16;
    localparam int ARM = 4;

    logic          clk = 1'b0;
    logic          RST, iENABLE, iCLEAR, iFAULT, iPERIOD_TICK;
    logic [BD-1:0] iFREQUENCY, iSTEP, iSPS_target, iDPS_target;
    logic          iSPS_target_sign, iDPS_target_sign;
    logic          oPSM_RST, oSPS_sign, oDPS_sign, oDONE;
    logic [BD-1:0] oSPS_value, oDPS_value;
    logic [2:0]    oSTATE;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    psm_ramp_sequencer #(.BITS_DATA(BD), .ARM_PERIODS(ARM)) dut (
        .CLK(clk), .RST(RST), .iENABLE(iENABLE), .iCLEAR(iCLEAR), .iFAULT(iFAULT),
        .iPERIOD_TICK(iPERIOD_TICK), .iFREQUENCY(iFREQUENCY), .iSTEP(iSTEP),
        .iSPS_target(iSPS_target), .iDPS_target(iDPS_target),
        .iSPS_target_sign(iSPS_target_sign), .iDPS_target_sign(iDPS_target_sign),
        .oPSM_RST(oPSM_RST), .oSPS_value(oSPS_value), .oDPS_value(oDPS_value),
        .oSPS_sign(oSPS_sign), .oDPS_sign(oDPS_sign), .oSTATE(oSTATE), .oDONE(oDONE)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: states 0 IDLE .. 5 FAULT, commands as plain signed ints.
    int m_state = 0;
    int m_cs    = 0;
    int m_cd    = 0;
    int m_cnt   = 0;
    int m_age   = 0;
    bit m_quiet = 1;

    function automatic int conv(input int mag, input bit neg, input int freq);
        int lim;
        int m;
        lim = (freq < 2) ? 0 : freq - 2;
        m   = (mag > lim) ? lim : mag;
        return neg ? -m : m;
    endfunction

    function automatic int step_to(input int c, input int t, input int s);
        int d;
        d = t - c;
        if (s == 0 || (d < 0 ? -d : d) <= s) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin
        int ts, td, nxt;
        ts = conv(int'(iSPS_target), iSPS_target_sign, int'(iFREQUENCY));
        td = conv(int'(iDPS_target), iDPS_target_sign, int'(iFREQUENCY));
        if (RST) begin
            m_state = 0; m_cs = 0; m_cd = 0; m_cnt = 0; m_age = 0; m_quiet = 1;
        end else begin
            nxt = m_state;
            if (iFAULT) begin
                nxt = 5; m_cs = 0; m_cd = 0;
            end else begin
                case (m_state)
                    0: if (iENABLE) begin nxt = 1; m_cnt = 0; end
                    1: if (!iENABLE) nxt = 0;
                       else if (iPERIOD_TICK) begin
                           m_cnt++;
                           if (m_cnt == ARM) nxt = 2;
                       end
                    2: if (!iENABLE) nxt = 4;
                       else if (iPERIOD_TICK) begin
                           m_cs = step_to(m_cs, ts, int'(iSTEP));
                           m_cd = step_to(m_cd, td, int'(iSTEP));
                           if (m_cs == ts && m_cd == td) nxt = 3;
                       end
                    3: if (!iENABLE) nxt = 4;
                       else if (m_cs != ts || m_cd != td) nxt = 2;
                    4: if (iENABLE) nxt = 2;
                       else if (iPERIOD_TICK) begin
                           m_cs = step_to(m_cs, 0, int'(iSTEP));
                           m_cd = step_to(m_cd, 0, int'(iSTEP));
                           if (m_cs == 0 && m_cd == 0) nxt = 0;
                       end
                    5: if (iCLEAR) nxt = 0;
                    default: nxt = 0;
                endcase
            end
            if (nxt == 0) begin
                if (m_state == 0) m_age++;
                else begin m_age = 0; m_quiet = (m_state == 5); end
            end
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state", int'(oSTATE), m_state);
            check("m_psm_rst", int'(oPSM_RST),
                  int'((m_state == 5) || (m_state == 0 && (m_quiet || m_age >= 1))));
            check("m_sps_value", int'(oSPS_value), iabs(m_cs));
            check("m_sps_sign", int'(oSPS_sign), int'(m_cs < 0));
            check("m_dps_value", int'(oDPS_value), iabs(m_cd));
            check("m_dps_sign", int'(oDPS_sign), int'(m_cd < 0));
            check("m_done", int'(oDONE), int'(m_state == 3));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tick after a spacer cycle; returns where the tick's effect is visible.
    task automatic tick();
        cyc(1);
        iPERIOD_TICK = 1'b1;
        @(negedge clk);
        iPERIOD_TICK = 1'b0;
    endtask

    int exp_up [5] = '{100, 200, 300, 400, 450};
    int exp_rv [3] = '{50, 50, 150};
    bit exp_rs [3] = '{1'b0, 1'b1, 1'b1};
    int exp_ds [3] = '{200, 100, 0};
    int exp_dd [3] = '{100, 0, 0};

    initial begin
        RST = 1'b1; iENABLE = 1'b0; iCLEAR = 1'b0; iFAULT = 1'b0; iPERIOD_TICK = 1'b0;
        iFREQUENCY = 16'd2000; iSTEP = 16'd100;
        iSPS_target = 16'd450; iDPS_target = 16'd0;
        iSPS_target_sign = 1'b0; iDPS_target_sign = 1'b0;
        cyc(3);
        cmp_en = 1;
        check("reset_psm_rst", int'(oPSM_RST), 1);
        check("reset_state", int'(oSTATE), 0);
        check("reset_sps", int'(oSPS_value), 0);
        check("reset_done", int'(oDONE), 0);
        RST = 1'b0;
        cyc(2);

        // Start-up
        iENABLE = 1'b1;
        cyc(1);
        check("arm_psm_rst_low", int'(oPSM_RST), 0);
        check("arm_state", int'(oSTATE), 1);
        repeat (ARM) tick();
        check("arm_done_state", int'(oSTATE), 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("startup_sps", int'(oSPS_value), exp_up[i]);
        end
        check("startup_run", int'(oSTATE), 3);
        check("startup_done", int'(oDONE), 1);

        // Sign reversal at step 100
        iSPS_target = 16'd150;
        cyc(1);
        repeat (3) tick();
        check("rev_pre_sps", int'(oSPS_value), 150);
        iSPS_target_sign = 1'b1;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rev_sps_value", int'(oSPS_value), exp_rv[i]);
            check("rev_sps_sign", int'(oSPS_sign), int'(exp_rs[i]));
        end
        check("rev_run", int'(oSTATE), 3);

        // Reversal through zero at step 75
        iSTEP = 16'd75;
        iSPS_target_sign = 1'b0;
        cyc(1);
        tick();
        tick();
        check("zero_value", int'(oSPS_value), 0);
        check("zero_sign", int'(oSPS_sign), 0);
        tick();
        tick();
        check("zero_run", int'(oSTATE), 3);

        // Clamp with immediate jump
        iSTEP = 16'd0;
        iFREQUENCY = 16'd1000;
        iDPS_target = 16'd5000;
        cyc(1);
        tick();
        check("clamp_dps", int'(oDPS_value), 998);

        // Shutdown
        iFREQUENCY = 16'd2000;
        iSPS_target = 16'd300;
        iDPS_target = 16'd200;
        cyc(1);
        tick();
        check("sd_run", int'(oSTATE), 3);
        iSTEP = 16'd100;
        iENABLE = 1'b0;
        cyc(1);
        check("sd_state", int'(oSTATE), 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sd_sps", int'(oSPS_value), exp_ds[i]);
            check("sd_dps", int'(oDPS_value), exp_dd[i]);
        end
        check("sd_idle", int'(oSTATE), 0);
        check("sd_psm_late", int'(oPSM_RST), 0);
        cyc(1);
        check("sd_psm_rst", int'(oPSM_RST), 1);

        // Re-enable during ramp-down
        iENABLE = 1'b1;
        cyc(1);
        repeat (ARM) tick();
        repeat (3) tick();
        check("re_run", int'(oSTATE), 3);
        iENABLE = 1'b0;
        cyc(1);
        tick();
        check("re_down_sps", int'(oSPS_value), 200);
        iENABLE = 1'b1;
        cyc(1);
        check("re_ramp", int'(oSTATE), 2);
        check("re_no_rst", int'(oPSM_RST), 0);
        tick();
        check("re_back_run", int'(oSTATE), 3);

        // Frequency drop: ramp down to the new limit, no instant clamp
        iSTEP = 16'd0;
        iSPS_target = 16'd1000;
        cyc(1);
        tick();
        iSTEP = 16'd300;
        iFREQUENCY = 16'd600;
        cyc(1);
        check("lim_hold", int'(oSPS_value), 1000);
        tick();
        check("lim_step", int'(oSPS_value), 700);
        tick();
        check("lim_final", int'(oSPS_value), 598);

        // Fault mid-ramp, clear ignored while fault held
        iSTEP = 16'd100;
        iFREQUENCY = 16'd2000;
        cyc(1);
        tick();
        iFAULT = 1'b1;
        cyc(1);
        check("flt_state", int'(oSTATE), 5);
        check("flt_psm", int'(oPSM_RST), 1);
        check("flt_sps", int'(oSPS_value), 0);
        iCLEAR = 1'b1;
        cyc(1);
        check("flt_clear_ignored", int'(oSTATE), 5);
        iFAULT = 1'b0; iCLEAR = 1'b0; iENABLE = 1'b0;
        cyc(1);
        iCLEAR = 1'b1;
        cyc(1);
        iCLEAR = 1'b0;
        check("flt_cleared", int'(oSTATE), 0);

        // Tick coinciding with fault
        iENABLE = 1'b1;
        cyc(1);
        repeat (ARM) tick();
        tick();
        check("sim_ramp_sps", int'(oSPS_value), 100);
        iPERIOD_TICK = 1'b1; iFAULT = 1'b1;
        cyc(1);
        iPERIOD_TICK = 1'b0; iFAULT = 1'b0;
        check("sim_fault", int'(oSTATE), 5);
        check("sim_sps", int'(oSPS_value), 0);
        iENABLE = 1'b0; iCLEAR = 1'b1;
        cyc(1);
        iCLEAR = 1'b0;

        // Frequency below 2 forces a zero limit
        iSTEP = 16'd0;
        iFREQUENCY = 16'd1;
        iENABLE = 1'b1;
        cyc(1);
        repeat (ARM) tick();
        tick();
        check("lim0_run", int'(oSTATE), 3);

        // Reset mid-run
        iFREQUENCY = 16'd2000;
        cyc(1);
        tick();
        check("rst_pre_sps", int'(oSPS_value), 1000);
        RST = 1'b1;
        cyc(1);
        check("rst_state", int'(oSTATE), 0);
        check("rst_psm", int'(oPSM_RST), 1);
        check("rst_sps", int'(oSPS_value), 0);
        check("rst_dps", int'(oDPS_value), 0);
        check("rst_done", int'(oDONE), 0);
        iENABLE = 1'b0;
        RST = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
